// File: rtl/reset_release_sequencer.sv
// reset_release_sequencer
//   Produces staggered active-low reset lines for downstream flop banks.
//   All lines are held low for HOLD_CYCLES. The lines are then released one
//   at a time, bit 0 first, with STAGGER_CYCLES between releases. When the
//   sequence is complete, a software request can restart it. The request
//   is acknowledged with a one-cycle pulse.
//
// Ports
//   clk           clock
//   reset         synchronous active-low reset
//   sw_rst_req    software re-reset request, level-sampled (honoured in DONE)
//   sw_rst_ack    one-cycle pulse when a request is accepted
//   rst_out_n     downstream active-low resets, bit 0 released first
//   all_released  high while every rst_out_n bit is 1
//
// States
//   HOLD    | all lines asserted, counting the hold-off period
//   RELEASE | releasing lines 1..NUM_OUT-1, one per stagger period
//   DONE    | all lines released, waiting for a software request
module reset_release_sequencer #(
  parameter int NUM_OUT        = 4,
  parameter int HOLD_CYCLES    = 16,
  parameter int STAGGER_CYCLES = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sw_rst_req,
  output logic               sw_rst_ack,
  output logic [NUM_OUT-1:0] rst_out_n,
  output logic               all_released
);

  localparam int MAX_CNT = (HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES : STAGGER_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);
  localparam int IDX_W   = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    RELEASE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               rel_now;
  logic               accept;
  logic [NUM_OUT-1:0] rst_d;
  logic               ack_d;
  logic               all_d;

  // State register. The outputs are registered here as well, so the reset
  // lines are driven directly from flops.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= HOLD;
      cnt_q        <= '0;
      idx_q        <= '0;
      rst_out_n    <= '0;
      sw_rst_ack   <= 1'b0;
      all_released <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      rst_out_n    <= rst_d;
      sw_rst_ack   <= ack_d;
      all_released <= all_d;
    end
  end

  // Next-state logic. rel_now marks the edge on which line idx_q is released.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rel_now = 1'b0;
    accept  = 1'b0;
    unique case (state_q)
      HOLD: begin
        if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
          cnt_d   = '0;
          rel_now = 1'b1;
          if (NUM_OUT == 1) begin
            state_d = DONE;
          end else begin
            state_d = RELEASE;
            idx_d   = IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RELEASE: begin
        if (cnt_q == CNT_W'(STAGGER_CYCLES - 1)) begin
          cnt_d   = '0;
          rel_now = 1'b1;
          if (idx_q == IDX_W'(NUM_OUT - 1)) begin
            state_d = DONE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (sw_rst_req) begin
          accept  = 1'b1;
          state_d = HOLD;
          cnt_d   = '0;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = HOLD;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase
  end

  // Output logic: next values of the registered outputs.
  always_comb begin
    rst_d = rst_out_n;
    ack_d = accept;
    if (accept) begin
      rst_d = '0;
    end else if (rel_now) begin
      for (int i = 0; i < NUM_OUT; i++) begin
        if (idx_q == IDX_W'(i)) begin
          rst_d[i] = 1'b1;
        end
      end
    end
    all_d = &rst_d;
  end

endmodule
